keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_emulator_if.sv | 23 ++
 rtl/lfsr8.sv | 23 ++
 rtl/keypad_emulator.sv | 144 ++++++++++++++
 tb/tb_keypad_emulator.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad emulator: FSM states, key field
// widths, LFSR seed/step and the idle column value.
package keypad_pkg;

   typedef enum logic [2:0] {
      IDLE,
      BOUNCE_IN,
      HOLD,
      BOUNCE_OUT,
      GAP
   } state_e;

   localparam int KEY_ROW    = 2;
   localparam int KEY_COL    = 2;
   localparam int KEY_CODE_W = KEY_ROW + KEY_COL;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [3:0] COL_IDLE  = 4'hF;

   // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting toward the MSB.
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Keystroke request handshake plus the active-low row/column scan lines.
interface keypad_emulator_if;
   import keypad_pkg::*;

   logic                  key_valid;
   logic [KEY_CODE_W-1:0] key_code;
   logic [15:0]           hold_cycles;
   logic                  key_ready;
   logic [3:0]            r;
   logic [3:0]            c;
   logic                  pressed;

   modport master (
      output key_valid, key_code, hold_cycles, r,
      input  key_ready, c, pressed
   );

   modport slave (
      input  key_valid, key_code, hold_cycles, r,
      output key_ready, c, pressed
   );

endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR that supplies the contact-bounce pattern.
module lfsr8
   import keypad_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] out
);

   logic [7:0] lfsr_q, lfsr_d;

   always_comb lfsr_d = lfsr_next(lfsr_q);

   // NOTE: clocked state is written only with <= so every flop samples the
   // pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign out = lfsr_q;

endmodule

// File: rtl/keypad_emulator.sv
// Matrix-keypad keystroke emulator: one latched key closes onto the scanned
// row for a programmed time. Define KEYPAD_EMU_BOUNCE_EN for contact bounce.
module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int BOUNCE_LEN = 64,
   parameter int GAP_CYCLES = 16
)
(
   input  logic               clk,
   input  logic               reset,
   keypad_emulator_if.slave   kif
);

   state_e                state_q, state_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [KEY_CODE_W-1:0] code_q, code_d;
   logic                  contact_q, contact_d;
   logic [15:0]           hold_eff;
   logic                  cnt_last;
   logic [KEY_ROW-1:0]    row;
   logic [KEY_COL-1:0]    col;
   logic [3:0]            col_out;

   // A requested hold of zero still produces one closed cycle.
   assign hold_eff = (kif.hold_cycles == 16'd0) ? 16'd1 : kif.hold_cycles;
   assign cnt_last = (cnt_q <= 16'd1);
   assign row      = code_q[KEY_CODE_W-1:KEY_COL];
   assign col      = code_q[KEY_COL-1:0];

`ifdef KEYPAD_EMU_BOUNCE_EN
   logic [7:0]  lfsr_out;
   logic        bounce_bit;
   logic        unused_lfsr_hi;
   logic [15:0] hold_q, hold_d;

   lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .out   (lfsr_out)
   );

   assign bounce_bit     = lfsr_out[0];
   assign unused_lfsr_hi = ^lfsr_out[7:1];

   // The hold length must survive BOUNCE_IN before it is loaded.
   always_ff @(posedge clk) begin
      if (reset) hold_q <= '0;
      else       hold_q <= hold_d;
   end
`else
   localparam int unused_bounce_len = BOUNCE_LEN;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         code_q    <= '0;
         contact_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         code_q    <= code_d;
         contact_q <= contact_d;
      end
   end

   // Next-state and duration counter.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can leave it
      // unassigned and infer a latch.
      state_d = state_q;
      cnt_d   = cnt_last ? cnt_q : cnt_q - 16'd1;
      code_d  = code_q;
`ifdef KEYPAD_EMU_BOUNCE_EN
      hold_d  = hold_q;
`endif
      unique case (state_q)
         IDLE: begin
            cnt_d = cnt_q;
            if (kif.key_valid) begin
               code_d  = kif.key_code;
`ifdef KEYPAD_EMU_BOUNCE_EN
               hold_d  = hold_eff;
               state_d = BOUNCE_IN;
               cnt_d   = 16'(BOUNCE_LEN);
`else
               state_d = HOLD;
               cnt_d   = hold_eff;
`endif
            end
         end
`ifdef KEYPAD_EMU_BOUNCE_EN
         BOUNCE_IN: if (cnt_last) begin
            state_d = HOLD;
            cnt_d   = hold_q;
         end
         HOLD: if (cnt_last) begin
            state_d = BOUNCE_OUT;
            cnt_d   = 16'(BOUNCE_LEN);
         end
         BOUNCE_OUT: if (cnt_last) begin
            state_d = GAP;
            cnt_d   = 16'(GAP_CYCLES);
         end
`else
         HOLD: if (cnt_last) begin
            state_d = GAP;
            cnt_d   = 16'(GAP_CYCLES);
         end
`endif
         GAP: if (cnt_last) begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: contact registered for the state being entered, column return.
   always_comb begin
      contact_d = 1'b0;
      case (state_d)
         HOLD:                  contact_d = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
         BOUNCE_IN, BOUNCE_OUT: contact_d = bounce_bit;
`endif
         default:               contact_d = 1'b0;
      endcase

      col_out = COL_IDLE;
      if (contact_q && !kif.r[row]) col_out[col] = 1'b0;
   end

   assign kif.key_ready = (state_q == IDLE);
   assign kif.pressed   = contact_q;
   assign kif.c         = col_out;

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomised scoreboard bench for keypad_emulator; honours KEYPAD_EMU_BOUNCE_EN.
module tb_keypad_emulator;

   localparam int BL  = 8;
   localparam int GAP = 16;
`ifdef KEYPAD_EMU_BOUNCE_EN
   localparam int BOFS = BL;
`else
   localparam int BOFS = 0;
`endif

   typedef struct packed {
      logic       ready;
      logic       pressed;
      logic [3:0] c;
   } obs_t;

   logic clk = 1'b0;
   logic reset;

   keypad_emulator_if kif ();

   keypad_emulator #(.BOUNCE_LEN(BL), .GAP_CYCLES(GAP)) dut (
      .clk   (clk),
      .reset (reset),
      .kif   (kif)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   obs_t exp_q[$];
   int   busy_len_q[$];

   // Reference model: a keystroke is a queue of per-cycle contact values
   // (0, 1, or 2 = "whatever the LFSR bit is that cycle").
   int         sched[$];
   bit         busy_m;
   bit         contact_m;
   logic [7:0] lfsr_m;
   logic [3:0] code_m;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_edge();
      int  h;
      int  e;
      if (reset) begin
         sched.delete();
         busy_len_q.delete();
         busy_m    = 1'b0;
         contact_m = 1'b0;
         lfsr_m    = 8'hA5;
         code_m    = 4'h0;
      end else begin
         if (kif.key_valid && !busy_m) begin
            code_m = kif.key_code;
            h = (kif.hold_cycles == 16'd0) ? 1 : int'(kif.hold_cycles);
`ifdef KEYPAD_EMU_BOUNCE_EN
            repeat (BL) sched.push_back(2);
`endif
            repeat (h) sched.push_back(1);
`ifdef KEYPAD_EMU_BOUNCE_EN
            repeat (BL) sched.push_back(2);
`endif
            repeat (GAP) sched.push_back(0);
            busy_len_q.push_back(sched.size());
         end
         if (sched.size() > 0) begin
            e = sched.pop_front();
            contact_m = (e == 2) ? lfsr_m[0] : (e == 1);
            busy_m    = 1'b1;
         end else begin
            contact_m = 1'b0;
            busy_m    = 1'b0;
         end
         lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
      end
   endtask

   function automatic obs_t expect_obs(input logic [3:0] rr);
      obs_t o;
      o.ready   = !busy_m;
      o.pressed = contact_m;
      o.c       = 4'hF;
      if (contact_m && rr[code_m[3:2]] == 1'b0) o.c[code_m[1:0]] = 1'b0;
      return o;
   endfunction

   // One clock: the model consumes the inputs seen at this edge, then the
   // inputs for the next edge are applied and the expected outputs queued.
   task automatic cycle(input logic v, input logic [3:0] code, input logic [15:0] hold,
                        input logic [3:0] rr, input logic rst);
      @(posedge clk);
      model_edge();
      #1;
      kif.key_valid   = v;
      kif.key_code    = code;
      kif.hold_cycles = hold;
      kif.r           = rr;
      reset           = rst;
      exp_q.push_back(expect_obs(rr));
   endtask

   task automatic idle(input int n, input logic [3:0] rr);
      repeat (n) cycle(1'b0, 4'h0, 16'd0, rr, 1'b0);
   endtask

   initial begin : monitor
      obs_t act;
      obs_t e;
      int   run;
      run = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {kif.key_ready, kif.pressed, kif.c};
            check("cycle_outputs", 32'(act), 32'(e));
         end
         if (kif.key_ready === 1'b0) run++;
         else if (kif.key_ready === 1'b1) begin
            if (run > 0 && busy_len_q.size() > 0) check("busy_length", run, busy_len_q.pop_front());
            run = 0;
         end
      end
   end

   initial begin : stim
      logic [3:0] rr;
      kif.key_valid   = 1'b0;
      kif.key_code    = 4'h0;
      kif.hold_cycles = 16'd0;
      kif.r           = 4'hF;
      reset           = 1'b1;
      busy_m          = 1'b0;
      contact_m       = 1'b0;
      lfsr_m          = 8'hA5;
      code_m          = 4'h0;

      // Reset for three edges, then idle outputs under two row patterns.
      cycle(1'b0, 4'h0, 16'd0, 4'h0, 1'b1);
      cycle(1'b0, 4'h0, 16'd0, 4'h0, 1'b1);
      cycle(1'b0, 4'h0, 16'd0, 4'h0, 1'b0);
      idle(2, 4'h0);
      idle(2, 4'hE);

      // Clean key on the matching row, then on a non-matching row.
      cycle(1'b1, 4'h6, 16'd10, 4'b1011, 1'b0);
      idle(BOFS * 2 + 40, 4'b1011);
      cycle(1'b1, 4'h6, 16'd10, 4'b1110, 1'b0);
      idle(BOFS * 2 + 40, 4'b1110);

      // Second request during HOLD is ignored; zero hold gives one cycle.
      cycle(1'b1, 4'h6, 16'd12, 4'b1011, 1'b0);
      idle(BOFS + 3, 4'b1011);
      repeat (3) cycle(1'b1, 4'h1, 16'd5, 4'b1011, 1'b0);
      idle(BOFS * 2 + 40, 4'b1011);
      cycle(1'b1, 4'h9, 16'd0, 4'b1011, 1'b0);
      idle(BOFS * 2 + 30, 4'b1011);

      // Reset in HOLD, reset colliding with a request, then a normal key.
      cycle(1'b1, 4'h6, 16'd20, 4'b1011, 1'b0);
      idle(BOFS + 5, 4'b1011);
      cycle(1'b0, 4'h0, 16'd0, 4'b1011, 1'b1);
      cycle(1'b1, 4'h3, 16'd4, 4'b1011, 1'b1);
      cycle(1'b0, 4'h0, 16'd0, 4'b0111, 1'b0);
      cycle(1'b1, 4'hC, 16'd3, 4'b0111, 1'b0);
      idle(BOFS * 2 + 30, 4'b0111);

      // Random traffic with multi-row scans and occasional resets.
      repeat (1500) begin
         case ($urandom_range(0, 3))
            0:       rr = 4'hF;
            1:       rr = 4'h0;
            2:       rr = ~(4'b0001 << $urandom_range(0, 3));
            default: rr = 4'($urandom);
         endcase
         cycle(($urandom_range(0, 5) == 0), 4'($urandom), 16'($urandom_range(0, 20)),
               rr, ($urandom_range(0, 299) == 0));
      end
      idle(BOFS * 2 + 60, 4'hF);

      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
